sel_mux_pipe: RTL

- Parametrised, registered N-channel selector; successor to the fixed 4-channel, 4-bit combinational code-select mux.
- Per transaction: a select code indexes a run-time programmable code->channel map table; the mapped channel's word is forwarded, and unmapped codes produce a DEFAULT word.
- Results pass through a 2-entry output buffer with valid/ready on both sides.
- Sits between datapath sources and consumers that need back-pressure and a reconfigurable routing map.

---
 rtl/sel_mux_pipe.sv | 102 ++++++++++
 1 files changed

// File: rtl/sel_mux_pipe.sv
// Registered N-channel selector: a programmable code->channel map picks one input word,
// results queue in a 2-entry valid/ready buffer; unmapped codes yield DEFAULT and are counted.
module sel_mux_pipe #(
    parameter int W = 4,
    parameter int N = 4,
    parameter int SW = 4,
    parameter logic [W-1:0] DEFAULT = {W{1'b1}}
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [N*W-1:0]         in_data,
    input  logic [SW-1:0]          in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_hit,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   cfg_we,
    input  logic [SW-1:0]          cfg_code,
    input  logic                   cfg_en,
    input  logic [$clog2(N)-1:0]   cfg_chan,
    output logic [15:0]            miss_count
);

    localparam int CW = $clog2(N);
    localparam int DEPTH = 1 << SW;

    logic          map_en   [DEPTH];
    logic [CW-1:0] map_chan [DEPTH];

    logic [W-1:0]  buf_data [2];
    logic          buf_hit  [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    occ;

    logic          accept;
    logic          pop;
    logic          lk_hit;
    logic [CW-1:0] lk_chan;
    logic [W-1:0]  lk_word;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? buf_data[rd_ptr] : DEFAULT;
    assign out_hit   = out_valid && buf_hit[rd_ptr];

    // An enabled entry pointing past the last channel behaves as unmapped.
    always_comb begin
        lk_chan = map_chan[in_sel];
        lk_hit  = map_en[in_sel] && (32'(lk_chan) < 32'(N));
        lk_word = DEFAULT;
        for (int k = 0; k < N; k++) begin
            if (lk_hit && (lk_chan == CW'(k)))
                lk_word = in_data[k*W +: W];
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int k = 0; k < DEPTH; k++) begin
                map_en[k]   <= (k < N);
                map_chan[k] <= (k < N) ? CW'(k) : '0;
            end
        end else if (cfg_we) begin
            map_en[cfg_code]   <= cfg_en;
            map_chan[cfg_code] <= cfg_chan;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            buf_data[0] <= DEFAULT;
            buf_data[1] <= DEFAULT;
            buf_hit[0]  <= 1'b0;
            buf_hit[1]  <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (accept) begin
                buf_data[wr_ptr] <= lk_word;
                buf_hit[wr_ptr]  <= lk_hit;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(accept) - 2'(pop);
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            miss_count <= 16'd0;
        else if (accept && !lk_hit && (miss_count != 16'hFFFF))
            miss_count <= miss_count + 16'd1;
    end

endmodule
